// File: rtl/tts_pkg.sv
// -----------------------------------------------------------------------------
// tts_pkg
// Shared types and helpers for the truth-table sweeper.
//   tts_state_e : sweep sequencer states
//   tt_width(n) : number of truth-table rows for an n-input gate (2**n)
// -----------------------------------------------------------------------------
package tts_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } tts_state_e;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
// Host-side control/result bundle of the truth-table sweeper.
//   start, abort, expected, result_ready : host -> sweeper
//   busy, result, result_valid, match    : sweeper -> host
// Modports: master = host, slave = sweeper.
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    import tts_pkg::*;

    localparam int TT_W = tt_width(N_IN);

    logic            start;
    logic            abort;
    logic [TT_W-1:0] expected;
    logic            busy;
    logic [TT_W-1:0] result;
    logic            result_valid;
    logic            result_ready;
    logic            match;

    modport master (
        output start, abort, expected, result_ready,
        input  busy, result, result_valid, match
    );

    modport slave (
        input  start, abort, expected, result_ready,
        output busy, result, result_valid, match
    );

endinterface

// File: rtl/settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
// Loadable down-counter that stops at zero.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   zero       : counter currently at zero
// -----------------------------------------------------------------------------
module settle_timer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int W             = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Drives every input combination of a combinational gate, holds each for a
// settle window, captures the gate output into a truth-table word and
// compares it against a golden table latched at start.
//   clk, rst_n : clock, async active-low reset
//   host       : control/result bundle (slave modport)
//   stim       : gate inputs, stim[N_IN-1] is the MSB of the combination index
//   resp       : gate output
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start (only accepted with no pending result)
// SETTLE  | stim held at idx while the settle timer runs down
// CAPTURE | one cycle: sample resp into result[idx], advance or finish
// DONE    | result/match valid, waiting for result_ready
// -----------------------------------------------------------------------------
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  host,
    output logic [N_IN-1:0]       stim,
    input  logic                  resp
);

    localparam int TT_W  = tt_width(N_IN);
    localparam int IDX_W = N_IN + 1;
    localparam int TMR_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    // idx carries one extra bit so the last-row compare never aliases
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE_CYCLES - 1);

    tts_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [TT_W-1:0] exp_q, exp_d;
    logic [TT_W-1:0] result_q, result_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            match_q, match_d;
    logic            tmr_load;
    logic            tmr_zero;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .W             (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (TMR_LOAD),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stim_d   = stim_q;
        exp_d    = exp_q;
        result_d = result_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        match_d  = match_q;
        tmr_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (host.start && !valid_q) begin
                    stim_d   = '0;
                    idx_d    = '0;
                    exp_d    = host.expected;
                    result_d = '0;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
            end

            SETTLE: begin
                if (host.abort) begin
                    stim_d  = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    state_d = CAPTURE;
                end
            end

            CAPTURE: begin
                // abort wins over the capture: the current row is not written
                if (host.abort) begin
                    stim_d  = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    result_d[idx_q[N_IN-1:0]] = resp;
                    if (idx_q == IDX_LAST) begin
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                        match_d = (result_d == exp_q);
                        stim_d  = '0;
                        state_d = DONE;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        stim_d   = idx_d[N_IN-1:0];
                        tmr_load = 1'b1;
                        state_d  = SETTLE;
                    end
                end
            end

            DONE: begin
                if (host.result_ready) begin
                    valid_d = 1'b0;
                    match_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            stim_q   <= '0;
            exp_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            stim_q   <= stim_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
        end
    end

    assign stim              = stim_q;
    assign host.busy         = busy_q;
    assign host.result       = result_q;
    assign host.result_valid = valid_q;
    assign host.match        = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;
    import tts_pkg::*;

    localparam int N   = 3;
    localparam int S   = 2;
    localparam int TT  = 8;
    localparam int N2  = 2;
    localparam int S2  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    truth_table_sweeper_if #(.N_IN(N))  h1 ();
    truth_table_sweeper_if #(.N_IN(N2)) h2 ();

    // gate under test for instance 1: a truth table indexed by stim
    logic [N-1:0]  stim;
    logic          resp;
    logic [TT-1:0] gate_tt;
    assign resp = gate_tt[stim];

    // instance 2: 2-input XOR
    logic [N2-1:0] stim2;
    logic          resp2;
    assign resp2 = stim2[1] ^ stim2[0];

    truth_table_sweeper #(.N_IN(N), .SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (h1),
        .stim  (stim),
        .resp  (resp)
    );

    truth_table_sweeper #(.N_IN(N2), .SETTLE_CYCLES(S2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (h2),
        .stim  (stim2),
        .resp  (resp2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of instance 1 ----------------
    // mode: 0 idle, 1 sweeping, 2 result pending.  e counts edges since the
    // accepted start; row k is captured on edge (k+1)*(S+1).
    int            m_mode  = 0;
    int            m_e     = 0;
    int            m_k     = 0;
    logic [TT-1:0] m_exp   = '0;
    logic [TT-1:0] m_res   = '0;
    logic [N-1:0]  m_stim  = '0;
    logic          m_busy  = 1'b0;
    logic          m_valid = 1'b0;
    logic          m_match = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_e = 0; m_exp = '0; m_res = '0; m_stim = '0;
            m_busy = 1'b0; m_valid = 1'b0; m_match = 1'b0;
        end else begin
            case (m_mode)
                0: if (h1.start && !m_valid) begin
                    m_mode = 1; m_e = 0; m_exp = h1.expected; m_res = '0;
                    m_stim = '0; m_busy = 1'b1;
                end
                1: if (h1.abort) begin
                    m_mode = 0; m_stim = '0; m_busy = 1'b0;
                end else begin
                    m_e++;
                    if (m_e % (S + 1) == 0) begin
                        m_k = m_e / (S + 1) - 1;
                        m_res[m_k] = gate_tt[m_k];
                        if (m_k == TT - 1) begin
                            m_mode = 2; m_busy = 1'b0; m_valid = 1'b1;
                            m_match = (m_res == m_exp); m_stim = '0;
                        end else begin
                            m_stim = N'(m_k + 1);
                        end
                    end
                end
                default: if (h1.result_ready) begin
                    m_mode = 0; m_valid = 1'b0; m_match = 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        check("stim",         32'(stim),            32'(m_stim));
        check("busy",         32'(h1.busy),         32'(m_busy));
        check("result_valid", 32'(h1.result_valid), 32'(m_valid));
        check("match",        32'(h1.match),        32'(m_match));
        check("result",       32'(h1.result),       32'(m_res));
    end

    int   n_valid_rise = 0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (h1.result_valid && !prev_v) n_valid_rise++;
        prev_v = h1.result_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input logic [TT-1:0] exp);
        @(posedge clk); #2;
        h1.expected = exp;
        h1.start    = 1'b1;
        @(posedge clk); #2;
        h1.start    = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (h1.result_valid) break;
        end
        if (!h1.result_valid) check("valid_timeout", 32'(h1.result_valid), 32'd1);
    endtask

    task automatic pulse_ready();
        @(posedge clk); #2;
        h1.result_ready = 1'b1;
        @(posedge clk); #2;
        h1.result_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stim"},   32'(stim),            32'd0);
        check({tag, "_busy"},   32'(h1.busy),         32'd0);
        check({tag, "_result"}, 32'(h1.result),       32'd0);
        check({tag, "_valid"},  32'(h1.result_valid), 32'd0);
        check({tag, "_match"},  32'(h1.match),        32'd0);
    endtask

    logic [1:0] seq2 [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

    initial begin
        int n;
        int base;
        int dly;
        logic [TT-1:0] g;
        logic [TT-1:0] e;
        logic do_abort;

        h1.start = 1'b0; h1.abort = 1'b0; h1.expected = '0; h1.result_ready = 1'b0;
        h2.start = 1'b0; h2.abort = 1'b0; h2.expected = '0; h2.result_ready = 1'b0;
        gate_tt = 8'hA0;

        #1 rst_n = 1'b0;
        #20;
        check_all_zero("reset");
        @(posedge clk); #2 rst_n = 1'b1;

        // 1: out = in2 & in0, on-set {5,7}
        do_start(8'hA0);
        wait_valid(n);
        check("t1_latency", 32'(n), 32'd24);
        check("t1_result",  32'(h1.result), 32'hA0);
        check("t1_match",   32'(h1.match),  32'd1);
        check("t1_busy",    32'(h1.busy),   32'd0);
        pulse_ready();

        // 2: mismatch, result held while not consumed
        do_start(8'h80);
        wait_valid(n);
        check("t2_result", 32'(h1.result), 32'hA0);
        check("t2_match",  32'(h1.match),  32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("t2_hold_valid",  32'(h1.result_valid), 32'd1);
        check("t2_hold_result", 32'(h1.result),       32'hA0);
        pulse_ready();
        #1;
        check("t2_valid_clr", 32'(h1.result_valid), 32'd0);
        check("t2_busy",      32'(h1.busy),         32'd0);

        // 3: start during sweep and during DONE is ignored
        base = n_valid_rise;
        do_start(8'hA0);
        repeat (5) @(posedge clk);
        #2 h1.start = 1'b1;
        @(posedge clk); #2 h1.start = 1'b0;
        repeat (7) @(posedge clk);
        #2 h1.start = 1'b1;
        @(posedge clk); #2 h1.start = 1'b0;
        wait_valid(n);
        #1 h1.start = 1'b1;
        repeat (2) @(posedge clk);
        #2 h1.start = 1'b0;
        #1 check("t3_busy_done", 32'(h1.busy), 32'd0);
        pulse_ready();
        repeat (30) @(posedge clk);
        #1;
        check("t3_one_result", 32'(n_valid_rise - base), 32'd1);
        check("t3_idle_busy",  32'(h1.busy), 32'd0);

        // 4: abort mid-sweep, then a clean sweep
        gate_tt = 8'h5C;
        do_start(8'h5C);
        repeat (9) @(posedge clk);
        #2 h1.abort = 1'b1;
        @(posedge clk); #2 h1.abort = 1'b0;
        #1;
        check("t4_abort_stim",  32'(stim),            32'd0);
        check("t4_abort_busy",  32'(h1.busy),         32'd0);
        check("t4_abort_valid", 32'(h1.result_valid), 32'd0);
        repeat (30) @(posedge clk);
        #1 check("t4_no_valid", 32'(h1.result_valid), 32'd0);
        do_start(8'h5C);
        wait_valid(n);
        check("t4_result", 32'(h1.result), 32'h5C);
        check("t4_match",  32'(h1.match),  32'd1);
        pulse_ready();

        // start and abort together: start wins, abort cancels the next cycle
        @(posedge clk); #2 h1.start = 1'b1; h1.abort = 1'b1;
        @(posedge clk); #2 h1.start = 1'b0;
        @(posedge clk); #2 h1.abort = 1'b0;
        #1;
        check("t4b_busy",  32'(h1.busy),         32'd0);
        check("t4b_valid", 32'(h1.result_valid), 32'd0);

        // 5: asynchronous reset mid-sweep
        gate_tt = 8'hA0;
        do_start(8'hA0);
        repeat (12) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("t5_reset");
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t5_idle_busy", 32'(h1.busy), 32'd0);
        check("t5_idle_stim", 32'(stim),    32'd0);

        // randomized sweeps
        for (int it = 0; it < 25; it++) begin
            @(posedge clk); #2;
            g = TT'($urandom);
            gate_tt = g;
            e = ($urandom_range(0, 1) == 1) ? g : TT'($urandom);
            do_abort = ($urandom_range(0, 4) == 0);
            do_start(e);
            if (do_abort) begin
                dly = $urandom_range(0, 18);
                repeat (dly) @(posedge clk);
                #2 h1.abort = 1'b1;
                @(posedge clk); #2 h1.abort = 1'b0;
                repeat (3) @(posedge clk);
                #1 check("rnd_abort_busy", 32'(h1.busy), 32'd0);
            end else begin
                wait_valid(n);
                check("rnd_latency", 32'(n), 32'd24);
                check("rnd_result",  32'(h1.result), 32'(g));
                check("rnd_match",   32'(h1.match),  32'(g == e));
                dly = $urandom_range(0, 5);
                repeat (dly) @(posedge clk);
                pulse_ready();
            end
        end

        // 6: N_IN=2, SETTLE_CYCLES=1, XOR
        @(posedge clk); #2 h2.start = 1'b1; h2.expected = 4'b0110;
        @(posedge clk); #2 h2.start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("t6_stim", 32'(stim2), 32'(seq2[j]));
            check("t6_busy", 32'(h2.busy), 32'd1);
        end
        @(negedge clk);
        check("t6_valid",  32'(h2.result_valid), 32'd1);
        check("t6_result", 32'(h2.result),       32'b0110);
        check("t6_match",  32'(h2.match),        32'd1);
        check("t6_stim0",  32'(stim2),           32'd0);
        @(posedge clk); #2 h2.result_ready = 1'b1;
        @(posedge clk); #2 h2.result_ready = 1'b0;
        #1 check("t6_valid_clr", 32'(h2.result_valid), 32'd0);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
